// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage and the decoder that consumes IF/ID.
// The all-zero instruction is the single bubble encoding; the decoder treats
// it as a no-op, so both sides must agree on NOP_INSTR.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  // Redirect targets are word aligned by dropping the two low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // A raw target is misaligned when either low bit is set.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold, flush and load.
// Flush wins over stall and loads a bubble (NOP, PC+4 of zero, not valid).
// Stall without flush holds the current contents.
// Otherwise the fetched instruction and its PC+4 are captured as valid.
// valid_o qualifies instr_o/pcplus4_o; there is no backpressure other than stall_i.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  // Next-state selection: flush > stall (hold) > load.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (flush_i) begin
      instr_d   = NOP_INSTR;
      pcplus4_d = 32'h0000_0000;
      valid_d   = 1'b0;
    end else if (!stall_i) begin
      instr_d   = instr_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end
  end

  // IF/ID state register, cleared asynchronously to a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect selection, misalignment
// tracking and the IF/ID register.
// Build option: BRANCH_DELAY_SLOT_EN. When defined, the instruction fetched in
// a redirect cycle enters IF/ID as a delay slot; when undefined it is squashed.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic        Misaligned
);

  logic [31:0] pc_q, pc_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] pc_plus4;
  logic [31:0] raw_target;
  logic        redirect;
  logic        if_id_flush;

  // PC+4 wraps naturally in 32 bits.
  assign pc_plus4 = pc_q + PC_INC;

  // A redirect only takes effect when not stalled; branch beats jump.
  assign redirect   = !Stall && (BranchTaken || Jump);
  assign raw_target = BranchTaken ? BranchTarget : JumpTarget;

  // Next PC: hold on stall, else aligned redirect target, else sequential.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (!Stall) begin
      if (redirect) begin
        pc_d = align_word(raw_target);
        if (is_misaligned(raw_target)) begin
          misaligned_d = 1'b1;
        end
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // PC and sticky misalignment flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // The instruction fetched alongside a redirect is kept as a delay slot.
  assign if_id_flush = Flush;
`else
  // The instruction fetched alongside a redirect is on the wrong path.
  assign if_id_flush = Flush || redirect;
`endif

  if_id_reg u_if_id_reg (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .stall_i   (Stall),
    .flush_i   (if_id_flush),
    .instr_i   (IMemData),
    .pcplus4_i (pc_plus4),
    .instr_o   (Instruction_ID),
    .pcplus4_o (PCPlus4_ID),
    .valid_o   (Valid_ID)
  );

  assign IMemAddr   = pc_q;
  assign Misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random stimulus,
// checked against a cycle-level reference model through an expected queue.
module tb_fetch_stage;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam int EW = 98;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic [31:0] Instruction_ID;
  logic [31:0] PCPlus4_ID;
  logic        Valid_ID;
  logic        Misaligned;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_mis;

  fetch_stage dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall          (Stall),
    .Flush          (Flush),
    .BranchTaken    (BranchTaken),
    .BranchTarget   (BranchTarget),
    .Jump           (Jump),
    .JumpTarget     (JumpTarget),
    .IMemAddr       (IMemAddr),
    .IMemData       (IMemData),
    .Instruction_ID (Instruction_ID),
    .PCPlus4_ID     (PCPlus4_ID),
    .Valid_ID       (Valid_ID),
    .Misaligned     (Misaligned)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // Instruction memory: never returns zero for an aligned address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[31:16] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign IMemData = imem(IMemAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Called at posedge+2: applies one cycle of inputs, records what the
  // pipeline should look like after the next edge, then advances.
  task automatic step(input bit st, input bit fl, input bit br, input logic [31:0] bt,
                      input bit jp, input logic [31:0] jt);
    logic [31:0] fetched;
    logic [31:0] tgt;
    bit          taken;
    Stall        = st;
    Flush        = fl;
    BranchTaken  = br;
    BranchTarget = bt;
    Jump         = jp;
    JumpTarget   = jt;

    fetched = imem(m_pc);
    taken   = !st && (br || jp);
    tgt     = br ? bt : jt;

    // what the decoder will see next cycle
    if (fl || (taken && !DS)) begin
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end else if (!st) begin
      m_instr = fetched;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
    end

    // where fetch goes next
    if (!st) begin
      if (taken) begin
        if (tgt % 4 != 0) m_mis = 1'b1;
        m_pc = tgt - (tgt % 4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end

    exp_q.push_back({m_pc, m_instr, m_pc4, m_valid, m_mis});
    @(posedge Clk);
    #2;
  endtask

  task automatic free_run();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset pulse placed away from the clock edge.
  task automatic pulse_reset();
    #3;
    Reset = 1'b1;
    #1;
    chk("async_rst_pc",    IMemAddr, 32'h0);
    chk("async_rst_instr", Instruction_ID, 32'h0);
    chk("async_rst_pc4",   PCPlus4_ID, 32'h0);
    chk("async_rst_valid", {31'h0, Valid_ID}, 32'h0);
    chk("async_rst_mis",   {31'h0, Misaligned}, 32'h0);
    model_reset();
    @(posedge Clk);
    #2;
    Reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc",    IMemAddr, e[97:66]);
        chk("sb_instr", Instruction_ID, e[65:34]);
        chk("sb_pc4",   PCPlus4_ID, e[33:2]);
        chk("sb_valid", {31'h0, Valid_ID}, {31'h0, e[1]});
        chk("sb_mis",   {31'h0, Misaligned}, {31'h0, e[0]});
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] bt;
    logic [31:0] jt;
    Reset        = 1'b1;
    Stall        = 1'b0;
    Flush        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = 32'h0;
    Jump         = 1'b0;
    JumpTarget   = 32'h0;
    model_reset();

    repeat (2) @(posedge Clk);
    #2;
    chk("rst_pc",    IMemAddr, 32'h0);
    chk("rst_instr", Instruction_ID, 32'h0);
    chk("rst_pc4",   PCPlus4_ID, 32'h0);
    chk("rst_valid", {31'h0, Valid_ID}, 32'h0);
    chk("rst_mis",   {31'h0, Misaligned}, 32'h0);
    Reset = 1'b0;

    // free run from reset
    free_run();
    chk("run1_pc",    IMemAddr, 32'h4);
    chk("run1_pc4",   PCPlus4_ID, 32'h4);
    chk("run1_valid", {31'h0, Valid_ID}, 32'h1);
    chk("run1_instr", Instruction_ID, 32'h5A5A_FFFF);
    free_run();
    chk("run2_pc",  IMemAddr, 32'h8);
    chk("run2_pc4", PCPlus4_ID, 32'h8);
    free_run();
    free_run();
    chk("run4_pc", IMemAddr, 32'h10);

    // stall at 0x10
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1 & 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    chk("stall_pc",  IMemAddr, 32'h10);
    chk("stall_pc4", PCPlus4_ID, 32'h10);
    free_run();
    chk("unstall_pc", IMemAddr, 32'h14);

    // branch beats jump
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    chk("br_pc", IMemAddr, 32'h40);
    if (!DS) begin
      chk("br_squash_instr", Instruction_ID, 32'h0);
      chk("br_squash_valid", {31'h0, Valid_ID}, 32'h0);
    end else begin
      chk("br_slot_pc4",   PCPlus4_ID, 32'h18);
      chk("br_slot_valid", {31'h0, Valid_ID}, 32'h1);
    end
    free_run();

    // flush while stalled
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("flush_instr", Instruction_ID, 32'h0);
    chk("flush_valid", {31'h0, Valid_ID}, 32'h0);
    chk("flush_pc",    IMemAddr, 32'h44);

    // misaligned jump
    chk("pre_mis", {31'h0, Misaligned}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
    chk("jmp_pc",  IMemAddr, 32'h100);
    chk("jmp_mis", {31'h0, Misaligned}, 32'h1);
    repeat (5) free_run();
    chk("mis_sticky", {31'h0, Misaligned}, 32'h1);
    chk("mis_pc",     IMemAddr, 32'h114);

    // wrap
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pre", IMemAddr, 32'hFFFF_FFFC);
    free_run();
    chk("wrap_pc", IMemAddr, 32'h0);

    // reset in the middle of a stall with a pending redirect
    Stall       = 1'b1;
    BranchTaken = 1'b1;
    BranchTarget = 32'h300;
    pulse_reset();
    free_run();
    chk("post_rst_pc",  IMemAddr, 32'h4);
    chk("post_rst_pc4", PCPlus4_ID, 32'h4);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bt = $urandom();
      jt = $urandom();
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      if (i == 150) pulse_reset();
      step($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 5) == 0, bt, $urandom_range(0, 5) == 0, jt);
    end

    repeat (2) @(posedge Clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
